// File: rtl/mult_arbiter.sv
// Round-robin front end for one shared pipelined multiplier: grants one requester
// per cycle, tracks requester IDs alongside the multiplier and routes products back.
module mult_arbiter #(
    parameter int BITWIDTH = 32,
    parameter int NREQ     = 4,
    parameter int LAT      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*BITWIDTH-1:0]   req_ain,
    input  logic [NREQ*BITWIDTH-1:0]   req_bin,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [2*BITWIDTH-1:0]      rsp_dout,
    output logic                       busy,
    output logic [BITWIDTH-1:0]        mul_ain,
    output logic [BITWIDTH-1:0]        mul_bin,
    output logic                       mul_en,
    input  logic [2*BITWIDTH-1:0]      mul_dout
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] idx;
    logic           gnt_any;
    logic           xfer;

    logic [LAT:0]   tag_vld;
    logic [IDW-1:0] tag_id [LAT+1];

    // Scan from ptr upward (with wrap); first valid requester wins.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_id    = ptr;
        idx       = ptr;
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
        if (gnt_any && !rst) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign xfer = gnt_any && !rst;
    assign busy = (|tag_vld) || (|rsp_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            mul_ain   <= '0;
            mul_bin   <= '0;
            mul_en    <= 1'b0;
            tag_vld   <= '0;
            rsp_valid <= '0;
            rsp_dout  <= '0;
            for (int k = 0; k <= LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            mul_en <= 1'b1;
            if (xfer) begin
                ptr     <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
                mul_ain <= req_ain[int'(gnt_id)*BITWIDTH +: BITWIDTH];
                mul_bin <= req_bin[int'(gnt_id)*BITWIDTH +: BITWIDTH];
            end else begin
                // Idle slots feed 0*0 so the multiplier never needs a stall.
                mul_ain <= '0;
                mul_bin <= '0;
            end

            tag_vld[0] <= xfer;
            tag_id[0]  <= gnt_id;
            for (int k = 1; k <= LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end

            if (tag_vld[LAT]) begin
                rsp_valid <= NREQ'(1) << tag_id[LAT];
                rsp_dout  <= mul_dout;
            end else begin
                rsp_valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural multiplier, reference grant model and a
// response scoreboard, plus per-scenario tasks with their own checks.
module tb_mult_arbiter;

    localparam int BW   = 32;
    localparam int NREQ = 4;
    localparam int LAT  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [BW-1:0]     a [NREQ];
    logic [BW-1:0]     b [NREQ];
    logic [NREQ*BW-1:0] req_ain, req_bin;
    logic [NREQ-1:0]   req_ready, rsp_valid;
    logic [2*BW-1:0]   rsp_dout;
    logic              busy;
    logic [BW-1:0]     mul_ain, mul_bin;
    logic              mul_en;
    logic [2*BW-1:0]   mul_dout;

    assign req_ain = {a[3], a[2], a[1], a[0]};
    assign req_bin = {b[3], b[2], b[1], b[0]};

    mult_arbiter #(.BITWIDTH(BW), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ain(req_ain), .req_bin(req_bin),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_dout(rsp_dout), .busy(busy),
        .mul_ain(mul_ain), .mul_bin(mul_bin), .mul_en(mul_en), .mul_dout(mul_dout)
    );

    always #5 clk = ~clk;

    // Multiplier model: sampling edge is the first of LAT edges.
    logic [2*BW-1:0] mpipe [LAT];
    always @(posedge clk) begin
        if (mul_en) begin
            mpipe[0] <= {32'b0, mul_ain} * {32'b0, mul_bin};
            for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
        end
    end
    assign mul_dout = mpipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [63:0] prod;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    int          gnt_log[$];
    int          rsp_id_log[$];
    logic [63:0] rsp_val_log[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_en  = 0;
    int          mptr    = 0;
    int          g, idx, rid;
    logic [NREQ-1:0] exp_rdy, exp_rsp;
    exp_t        e;

    // Reference arbiter and scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            g = -1;
            if (!rst) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (mptr + k) % NREQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            n_tests++;
            if (req_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL grant cyc=%0d got=%b want=%b", cyc, req_ready, exp_rdy);
            end
            n_tests++;
            if (busy !== (sbq.size() > 0)) begin
                n_fail++;
                $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, sbq.size() > 0);
            end
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                exp_rsp = '0;
                exp_rsp[sbq[0].id] = 1'b1;
                n_tests++;
                if (rsp_valid !== exp_rsp || rsp_dout !== sbq[0].prod) begin
                    n_fail++;
                    $display("FAIL response cyc=%0d got=%b/%h want=%b/%h",
                             cyc, rsp_valid, rsp_dout, exp_rsp, sbq[0].prod);
                end
                void'(sbq.pop_front());
            end else begin
                n_tests++;
                if (rsp_valid !== '0) begin
                    n_fail++;
                    $display("FAIL spurious_rsp cyc=%0d got=%b want=0", cyc, rsp_valid);
                end
            end
            if (rsp_valid !== '0) begin
                rid = -1;
                for (int k = 0; k < NREQ; k++) if (rsp_valid[k]) rid = k;
                rsp_id_log.push_back(rid);
                rsp_val_log.push_back(rsp_dout);
            end
            if (rst) begin
                sbq.delete();
                mptr = 0;
            end else if (g >= 0) begin
                e.id   = g;
                e.prod = {32'b0, a[g]} * {32'b0, b[g]};
                e.due  = cyc + LAT + 2;
                sbq.push_back(e);
                mptr = (g + 1) % NREQ;
                gnt_log.push_back(g);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        rsp_id_log.delete();
        rsp_val_log.delete();
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        req_valid = '0;
        repeat (LAT + 4) tick();
    endtask

    task automatic test_reset();
        req_valid = '1;
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if (req_ready !== '0 || rsp_valid !== '0 || rsp_dout !== '0 || busy !== 1'b0 ||
            mul_ain !== '0 || mul_bin !== '0 || mul_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got rdy=%b rv=%b rd=%h busy=%b ain=%h bin=%h en=%b want all 0",
                     req_ready, rsp_valid, rsp_dout, busy, mul_ain, mul_bin, mul_en);
        end
        req_valid = '0;
        mon_en = 1;
        tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if (mul_en !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_en_after_reset got=%b want=1", mul_en);
        end
    endtask

    task automatic test_single_op();
        int i;
        clear_logs();
        a[2] = 7; b[2] = 9;
        req_valid = 4'b0100;
        #1;
        n_tests++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_ready got=%b want=0100", req_ready);
        end
        tick();
        req_valid = '0;
        i = 1;
        n_tests++;
        if (mul_ain !== 32'd7 || mul_bin !== 32'd9) begin
            n_fail++;
            $display("FAIL single_issue got=%0d,%0d want=7,9", mul_ain, mul_bin);
        end
        while (rsp_valid === '0 && i < 20) begin
            n_tests++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL single_busy cycle=%0d got=%b want=1", i, busy);
            end
            if (i == 1) begin
                tick();
                n_tests++;
                if (mul_ain !== '0) begin
                    n_fail++;
                    $display("FAIL idle_slot got=%h want=0", mul_ain);
                end
            end else begin
                tick();
            end
            i++;
        end
        n_tests++;
        if (i != LAT + 2 || rsp_valid !== 4'b0100 || rsp_dout !== 64'd63) begin
            n_fail++;
            $display("FAIL single_rsp got lat=%0d rv=%b d=%0d want lat=%0d rv=0100 d=63",
                     i, rsp_valid, rsp_dout, LAT + 2);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0 || rsp_valid !== '0) begin
            n_fail++;
            $display("FAIL single_idle got busy=%b rv=%b want 0,0", busy, rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        clear_logs();
        for (int i = 0; i < NREQ; i++) begin a[i] = i + 1; b[i] = 1000; end
        req_valid = '1;
        repeat (8) tick();
        drain();
        n_tests++;
        if (gnt_log.size() != 8 || rsp_val_log.size() != 8) begin
            n_fail++;
            $display("FAIL rr_count got=%0d/%0d want=8/8", gnt_log.size(), rsp_val_log.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                n_tests++;
                if (gnt_log[j] != j % 4 || rsp_id_log[j] != j % 4 ||
                    rsp_val_log[j] !== 64'((j % 4 + 1) * 1000)) begin
                    n_fail++;
                    $display("FAIL rr_seq[%0d] got g=%0d id=%0d d=%0d want %0d,%0d,%0d",
                             j, gnt_log[j], rsp_id_log[j], rsp_val_log[j], j % 4, j % 4, (j % 4 + 1) * 1000);
                end
            end
        end
    endtask

    task automatic test_pointer_skip();
        do_reset();
        clear_logs();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1001;
        tick();
        tick();
        drain();
        n_tests++;
        if (gnt_log.size() != 3 || gnt_log[0] != 1 || gnt_log[1] != 3 || gnt_log[2] != 0) begin
            n_fail++;
            $display("FAIL ptr_skip got n=%0d seq=%p want 1,3,0", gnt_log.size(), gnt_log);
        end
    endtask

    task automatic test_width();
        clear_logs();
        a[0] = 32'hFFFF_FFFF; b[0] = 32'hFFFF_FFFF;
        req_valid = 4'b0001;
        tick();
        drain();
        n_tests++;
        if (rsp_val_log.size() != 1 || rsp_val_log[0] !== 64'hFFFF_FFFE_0000_0001) begin
            n_fail++;
            $display("FAIL width got n=%0d want FFFFFFFE00000001", rsp_val_log.size());
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        a[3] = 12345; b[3] = 678;
        req_valid = 4'b1000;
        repeat (5) tick();
        drain();
        n_tests++;
        if (gnt_log.size() != 5 || rsp_id_log.size() != 5) begin
            n_fail++;
            $display("FAIL back_to_back got g=%0d r=%0d want 5,5", gnt_log.size(), rsp_id_log.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        clear_logs();
        a[2] = 5; b[2] = 6;
        req_valid = 4'b0100;
        repeat (3) tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (LAT + 6) tick();
        n_tests++;
        if (rsp_id_log.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid got rsps=%0d busy=%b want 0,0", rsp_id_log.size(), busy);
        end
        req_valid = '1;
        #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_ptr got=%b want=0001", req_ready);
        end
        tick();
        drain();
    endtask

    task automatic test_random();
        clear_logs();
        for (int c = 0; c < 32; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                a[i] = $urandom & 32'h7FFF_FFFF;
                b[i] = $urandom & 32'h7FFF_FFFF;
            end
            req_valid = 4'($urandom_range(0, 15));
            tick();
        end
        drain();
        n_tests++;
        if (rsp_id_log.size() != gnt_log.size()) begin
            n_fail++;
            $display("FAIL random_count got=%0d want=%0d", rsp_id_log.size(), gnt_log.size());
        end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin a[i] = '0; b[i] = '0; end
        test_reset();
        test_single_op();
        test_round_robin();
        test_pointer_skip();
        test_width();
        test_back_to_back();
        test_reset_mid();
        test_random();
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL outstanding got=%0d want=0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
